// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised scratch RAM: state encoding,
// read-path select and default bus widths.
package ram_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 9;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_READY = 1'b1
    } ram_state_e;

    // Source of data_out for the most recent accepted read.
    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_ARRAY  = 2'd1,
        RD_BYPASS = 2'd2
    } rd_sel_e;

endpackage

// File: rtl/ram_array.sv
// Storage only: one synchronous write port and one registered read port,
// kept reset-free so the array maps onto iCE40 block RAM.
module ram_array #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] storage_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: no reset on the array or its read register; a reset would stop block-RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            storage_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= storage_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_init.sv
// Parametrised CPU-side RAM with a post-reset clear engine, range checking
// and a write-first bypass placed after the array's read register.
module ram_init
    import ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  out_of_range,
    output logic                  busy
);

    localparam int unsigned         CW         = $clog2(DEPTH);
    localparam logic [CW-1:0]       LAST_INDEX = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);

    ram_state_e            state_q, state_d;
    logic [CW-1:0]         clear_count_q, clear_count_d;
    logic                  valid_q, valid_d;
    logic                  oor_q, oor_d;
    rd_sel_e               sel_q, sel_d;
    logic [DATA_WIDTH-1:0] bypass_q, bypass_d;

    logic                  in_range;
    logic                  mem_we;
    logic                  mem_re;
    logic [CW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // One extra bit keeps DEPTH == 2**ADDR_WIDTH representable and avoids truncating the address.
    assign in_range = ({1'b0, address} < DEPTH_EXT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RAM_CLEAR;
            clear_count_q <= '0;
            valid_q       <= 1'b0;
            oor_q         <= 1'b0;
            sel_q         <= RD_ZERO;
            bypass_q      <= '0;
        end else begin
            state_q       <= state_d;
            clear_count_q <= clear_count_d;
            valid_q       <= valid_d;
            oor_q         <= oor_d;
            sel_q         <= sel_d;
            bypass_q      <= bypass_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        clear_count_d = clear_count_q;
        if (state_q == RAM_CLEAR) begin
            if (clear_count_q == LAST_INDEX) begin
                state_d = RAM_READY;
            end else begin
                clear_count_d = clear_count_q + 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = address[CW-1:0];
        mem_wdata = data_in;
        valid_d   = 1'b0;
        oor_d     = 1'b0;
        sel_d     = sel_q;
        bypass_d  = bypass_q;
        if (state_q == RAM_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_count_q;
            mem_wdata = INIT_VALUE;
        end else if (!reset) begin
            mem_we = write_enable && in_range;
            oor_d  = (write_enable || read_enable) && !in_range;
            if (read_enable) begin
                valid_d = 1'b1;
                if (!in_range) begin
                    sel_d = RD_ZERO;
                end else if (write_enable) begin
                    sel_d    = RD_BYPASS;
                    bypass_d = data_in;
                end else begin
                    sel_d  = RD_ARRAY;
                    mem_re = 1'b1;
                end
            end
        end
    end

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (address[CW-1:0]),
        .rdata_o (mem_rdata)
    );

    // sel_q only moves on an accepted read, so data_out holds between reads.
    always_comb begin
        case (sel_q)
            RD_ARRAY:  data_out = mem_rdata;
            RD_BYPASS: data_out = bypass_q;
            default:   data_out = '0;
        endcase
    end

    assign data_valid   = valid_q;
    assign out_of_range = oor_q;
    assign busy         = (state_q == RAM_CLEAR);

endmodule
